// File: rtl/house_pkg.sv
// rtl/house_pkg.sv - day phase encodings and hour boundaries shared by the timer and lighting stage
package house_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_RUN  = 2'd1,
      ST_LOAD = 2'd2
   } clk_state_t;

   localparam logic [3:0] PH_OFF     = 4'b0000;
   localparam logic [3:0] PH_MORNING = 4'b0001;
   localparam logic [3:0] PH_NOON    = 4'b0010;
   localparam logic [3:0] PH_EVENING = 4'b0100;
   localparam logic [3:0] PH_NIGHT   = 4'b1000;

   // First hour of each phase; night wraps through midnight.
   localparam logic [4:0] HR_MORNING = 5'd6;
   localparam logic [4:0] HR_NOON    = 5'd12;
   localparam logic [4:0] HR_EVENING = 5'd17;
   localparam logic [4:0] HR_NIGHT   = 5'd21;
   localparam logic [4:0] HR_MAX     = 5'd23;
   localparam logic [5:0] MIN_MAX    = 6'd59;

   function automatic logic [3:0] phase_of(input logic [4:0] hr);
      logic [3:0] ph;
      if (hr >= HR_NIGHT || hr < HR_MORNING) ph = PH_NIGHT;
      else if (hr >= HR_EVENING)             ph = PH_EVENING;
      else if (hr >= HR_NOON)                ph = PH_NOON;
      else                                   ph = PH_MORNING;
      return ph;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides timebase ticks down to a registered once-per-minute pulse
module tick_prescaler #(
   parameter int TICKS = 60
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic term
);

   localparam logic [7:0] LAST = 8'(TICKS - 1);

   logic [7:0] count_q, count_d;
   logic       term_q, term_d;

   // Clear wins over an increment, so a tick coinciding with a load is lost.
   always_comb begin
      count_d = count_q;
      term_d  = 1'b0;
      if (clr) begin
         count_d = 8'd0;
      end else if (inc) begin
         if (count_q == LAST) begin
            count_d = 8'd0;
            term_d  = 1'b1;
         end else begin
            count_d = count_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 8'd0;
         term_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         term_q  <= term_d;
      end
   end

   assign term = term_q;

endmodule

// File: rtl/day_phase_timer.sv
// rtl/day_phase_timer.sv - hour:minute clock with time load and one-hot day phase output
module day_phase_timer #(
   parameter int TICKS_PER_MIN = 60,
   parameter int RESET_HOUR    = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       tick,
   input  logic       set_valid,
   input  logic [4:0] set_hour,
   input  logic [5:0] set_min,
   output logic       set_ready,
   output logic       set_err,
   output logic [4:0] hour,
   output logic [5:0] minute,
   output logic [3:0] tcode,
   output logic       phase_chg
);
   import house_pkg::*;

   clk_state_t state_q, state_d;
   logic [4:0] hour_q, hour_d;
   logic [5:0] minute_q, minute_d;
   logic [3:0] tcode_q, tcode_d;
   logic       set_err_q, set_err_d;
   logic       phase_chg_q, phase_chg_d;
   logic       set_ready_q, set_ready_d;
   logic       load_acc, in_range, load_ok, adv;

   assign load_acc = set_valid & set_ready_q;
   assign in_range = (set_hour <= HR_MAX) && (set_min <= MIN_MAX);
   assign load_ok  = load_acc & in_range;

   tick_prescaler #(.TICKS(TICKS_PER_MIN)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (load_ok),
      .inc  ((state_q == ST_RUN) && tick),
      .term (adv)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_OFF;
         hour_q      <= 5'(RESET_HOUR);
         minute_q    <= 6'd0;
         tcode_q     <= PH_OFF;
         set_err_q   <= 1'b0;
         phase_chg_q <= 1'b0;
         set_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         hour_q      <= hour_d;
         minute_q    <= minute_d;
         tcode_q     <= tcode_d;
         set_err_q   <= set_err_d;
         phase_chg_q <= phase_chg_d;
         set_ready_q <= set_ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OFF:  if (load_ok) state_d = ST_LOAD; else if (en)  state_d = ST_RUN;
         ST_RUN:  if (load_ok) state_d = ST_LOAD; else if (!en) state_d = ST_OFF;
         ST_LOAD: state_d = en ? ST_RUN : ST_OFF;
         default: state_d = ST_OFF;
      endcase
   end

   // A pending minute advance is dropped when a load lands on the same cycle.
   always_comb begin
      hour_d   = hour_q;
      minute_d = minute_q;
      if (load_ok) begin
         hour_d   = set_hour;
         minute_d = set_min;
      end else if (adv) begin
         if (minute_q == MIN_MAX) begin
            minute_d = 6'd0;
            hour_d   = (hour_q == HR_MAX) ? 5'd0 : hour_q + 5'd1;
         end else begin
            minute_d = minute_q + 6'd1;
         end
      end
      tcode_d     = (state_q == ST_RUN) ? phase_of(hour_q) : PH_OFF;
      phase_chg_d = (tcode_d != tcode_q);
      set_err_d   = load_acc & ~in_range;
      set_ready_d = (state_d != ST_LOAD);
   end

   assign set_ready = set_ready_q;
   assign set_err   = set_err_q;
   assign hour      = hour_q;
   assign minute    = minute_q;
   assign tcode     = tcode_q;
   assign phase_chg = phase_chg_q;

endmodule

// File: tb/tb_day_phase_timer.sv
// tb/tb_day_phase_timer.sv - scenario and randomized checks of day_phase_timer against a time-of-day model
module tb_day_phase_timer;

   localparam int TPM  = 2;
   localparam int M_OFF = 0, M_RUN = 1, M_LOAD = 2;

   logic       clk, rst, en, tick, set_valid;
   logic [4:0] set_hour;
   logic [5:0] set_min;
   logic       set_ready, set_err, phase_chg;
   logic [4:0] hour;
   logic [5:0] minute;
   logic [3:0] tcode;
   logic [17:0] dut_vec;

   int n_vec = 0;
   int n_err = 0;

   int       m_mode, m_tod, m_pre;
   bit       m_adv, m_pchg, m_err, m_ready;
   logic [3:0] m_tcode;

   day_phase_timer #(.TICKS_PER_MIN(TPM), .RESET_HOUR(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .tick      (tick),
      .set_valid (set_valid),
      .set_hour  (set_hour),
      .set_min   (set_min),
      .set_ready (set_ready),
      .set_err   (set_err),
      .hour      (hour),
      .minute    (minute),
      .tcode     (tcode),
      .phase_chg (phase_chg)
   );

   assign dut_vec = {set_ready, set_err, hour, minute, tcode, phase_chg};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] ref_phase(input int h);
      if (h >= 6 && h <= 11)       return 4'b0001;
      else if (h >= 12 && h <= 16) return 4'b0010;
      else if (h >= 17 && h <= 20) return 4'b0100;
      else                         return 4'b1000;
   endfunction

   function automatic logic [17:0] exp_vec();
      return {m_ready, m_err, 5'(m_tod / 60), 6'(m_tod % 60), m_tcode, m_pchg};
   endfunction

   // Time is kept as minutes since midnight; outputs follow one edge behind the quantities they report.
   task automatic model_step();
      int nmode, ntod, npre;
      bit acc, ok, nadv;
      logic [3:0] ntc;
      if (rst) begin
         m_mode = M_OFF; m_tod = 6 * 60; m_pre = 0; m_adv = 0;
         m_tcode = 4'b0000; m_pchg = 0; m_err = 0; m_ready = 1;
      end else begin
         acc  = set_valid && (m_mode != M_LOAD);
         ok   = acc && (int'(set_hour) <= 23) && (int'(set_min) <= 59);
         ntc  = (m_mode == M_RUN) ? ref_phase(m_tod / 60) : 4'b0000;
         ntod = m_tod;
         if (ok)         ntod = int'(set_hour) * 60 + int'(set_min);
         else if (m_adv) ntod = (m_tod + 1) % 1440;
         nadv = (m_mode == M_RUN) && tick && !ok && (m_pre == TPM - 1);
         npre = m_pre;
         if (ok)                          npre = 0;
         else if (m_mode == M_RUN && tick) npre = (m_pre + 1) % TPM;
         nmode   = ok ? M_LOAD : (en ? M_RUN : M_OFF);
         m_err   = acc && !ok;
         m_pchg  = (ntc != m_tcode);
         m_tcode = ntc;
         m_tod   = ntod;
         m_adv   = nadv;
         m_pre   = npre;
         m_mode  = nmode;
         m_ready = (nmode != M_LOAD);
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic t, input logic sv,
                        input logic [4:0] h, input logic [5:0] m);
      rst = r; en = e; tick = t; set_valid = sv; set_hour = h; set_min = m;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 6'd30);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
         n_err++; $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec());
      end
      n_vec++;
      if (dut_vec !== {1'b1, 1'b0, 5'd6, 6'd0, 4'd0, 1'b0}) begin
         n_err++; $display("FAIL reset_values: got %h expected %h", dut_vec, {1'b1, 1'b0, 5'd6, 6'd0, 4'd0, 1'b0});
      end
   endtask

   task automatic test_rollover_phase();
      int pulses = 0;
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd11, 6'd59);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0);
      n_vec++;
      if ({hour, minute, tcode} !== {5'd11, 6'd59, 4'b0001}) begin
         n_err++; $display("FAIL rollover_loaded: got %h expected %h", {hour, minute, tcode}, {5'd11, 6'd59, 4'b0001});
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, (i == 0 || i == 2), 1'b0, 5'd0, 6'd0);
         pulses += int'(phase_chg);
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL rollover_cycle%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
      n_vec++;
      if ({hour, minute, tcode} !== {5'd12, 6'd0, 4'b0010}) begin
         n_err++; $display("FAIL rollover_final: got %h expected %h", {hour, minute, tcode}, {5'd12, 6'd0, 4'b0010});
      end
      n_vec++;
      if (pulses != 1) begin
         n_err++; $display("FAIL rollover_pulses: got %0d expected 1", pulses);
      end
   endtask

   task automatic test_midnight();
      int pulses = 0;
      drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd23, 6'd59);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0);
      n_vec++;
      if ({hour, minute, tcode} !== {5'd23, 6'd59, 4'b1000}) begin
         n_err++; $display("FAIL midnight_loaded: got %h expected %h", {hour, minute, tcode}, {5'd23, 6'd59, 4'b1000});
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, (i == 0 || i == 2), 1'b0, 5'd0, 6'd0);
         pulses += int'(phase_chg);
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL midnight_cycle%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
      n_vec++;
      if ({hour, minute, tcode, pulses != 0} !== {5'd0, 6'd0, 4'b1000, 1'b0}) begin
         n_err++; $display("FAIL midnight_final: got %h pulses %0d expected 00:00 tcode 8 pulses 0", {hour, minute, tcode}, pulses);
      end
   endtask

   task automatic test_bad_load();
      int errs = 0;
      int pulses = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 0)      drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd24, 6'd0);
         else if (i == 1) drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 6'd60);
         else             drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0);
         errs += int'(set_err);
         pulses += int'(phase_chg);
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL bad_load_cycle%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
      n_vec++;
      if (errs != 2 || pulses != 0) begin
         n_err++; $display("FAIL bad_load_pulses: got err %0d chg %0d expected err 2 chg 0", errs, pulses);
      end
      n_vec++;
      if ({hour, minute, tcode} !== {5'd0, 6'd0, 4'b1000}) begin
         n_err++; $display("FAIL bad_load_time: got %h expected %h", {hour, minute, tcode}, {5'd0, 6'd0, 4'b1000});
      end
   endtask

   task automatic test_load_vs_tick();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 6'd0);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 6'd30);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0);
      n_vec++;
      if ({hour, minute} !== {5'd8, 6'd30}) begin
         n_err++; $display("FAIL load_tick_time: got %h expected %h", {hour, minute}, {5'd8, 6'd30});
      end
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 6'd0);
         for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0);
         n_vec++;
         if ({hour, minute} !== {5'd8, 6'(30 + k)}) begin
            n_err++; $display("FAIL load_tick_after%0d: got %h expected %h", k, {hour, minute}, {5'd8, 6'(30 + k)});
         end
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL load_tick_model%0d: got %h expected %h", k, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_en_toggle();
      int pulses = 0;
      drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd18, 6'd0);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, (i != 0), 1'b0, 5'd0, 6'd0);
         pulses += int'(phase_chg);
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL en_off_cycle%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
      n_vec++;
      if ({hour, minute, tcode, 2'(pulses)} !== {5'd18, 6'd0, 4'b0000, 2'd1}) begin
         n_err++; $display("FAIL en_off_state: got %h pulses %0d expected 18:00 tcode 0 pulses 1", {hour, minute, tcode}, pulses);
      end
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0);
         pulses += int'(phase_chg);
      end
      n_vec++;
      if ({hour, minute, tcode, 2'(pulses)} !== {5'd18, 6'd0, 4'b0100, 2'd1}) begin
         n_err++; $display("FAIL en_on_state: got %h pulses %0d expected 18:00 tcode 4 pulses 1", {hour, minute, tcode}, pulses);
      end
   endtask

   task automatic test_rst_in_load();
      drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd14, 6'd45);
      n_vec++;
      if (set_ready !== 1'b0) begin
         n_err++; $display("FAIL rst_load_ready: got %b expected 0", set_ready);
      end
      drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 6'd3);
      n_vec++;
      if ({hour, minute, tcode, set_err, phase_chg} !== {5'd6, 6'd0, 4'd0, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL rst_load_values: got %h expected %h", {hour, minute, tcode, set_err, phase_chg}, {5'd6, 6'd0, 4'd0, 1'b0, 1'b0});
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 6'd0);
         n_vec++;
         if (dut_vec !== {1'b1, 1'b0, 5'd6, 6'd0, 4'd0, 1'b0}) begin
            n_err++; $display("FAIL rst_load_off%0d: got %h expected %h", i, dut_vec, {1'b1, 1'b0, 5'd6, 6'd0, 4'd0, 1'b0});
         end
      end
   endtask

   task automatic test_random();
      logic e = 1'b1;
      logic r, t, sv;
      logic [4:0] h;
      logic [5:0] m;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 15) == 0) e = ~e;
         r  = ($urandom_range(0, 63) == 0);
         sv = ($urandom_range(0, 9) == 0);
         t  = ($urandom_range(0, 2) == 0);
         h  = 5'($urandom_range(0, 27));
         m  = 6'($urandom_range(0, 63));
         if (sv && (h > 5'd23 || m > 6'd59)) t = 1'b0;
         drive(r, e, t, sv, h, m);
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_rollover_phase();
      test_midnight();
      test_bad_load();
      test_load_vs_tick();
      test_en_toggle();
      test_rst_in_load();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
